// File: rtl/sram_pkg.sv
// Shared definitions for the sram_1Mx8 Wishbone subsystem.
// Holds the mentor FSM state encoding and the default bus and tag widths.
package sram_pkg;
  localparam int SRAM_ADDR_WIDTH = 20;
  localparam int SRAM_DATA_WIDTH = 8;
  localparam int SRAM_TGA_WIDTH  = 1;
  localparam int SRAM_TGD_WIDTH  = 1;
  localparam int SRAM_TGC_WIDTH  = 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_REQ    = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;
endpackage

// File: rtl/sram_block_mentor.sv
// Wishbone classic block mentor: bursts i_len bytes to/from sram_1Mx8, one beat per STB with a one-cycle gap.
// Latency: one beat per response plus a gap cycle; the write stream is stalled (o_wready=0) outside FETCH.
module sram_block_mentor
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int LEN_WIDTH  = 8,
  parameter int MAX_RETRY  = 3
) (
  input  logic                      CLK_I,
  input  logic                      RST_I,
  input  logic                      i_start,
  input  logic                      i_write,
  input  logic [ADDR_WIDTH-1:0]     i_base_addr,
  input  logic [LEN_WIDTH-1:0]      i_len,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic                      i_wvalid,
  output logic                      o_wready,
  output logic [DATA_WIDTH-1:0]     o_rdata,
  output logic                      o_rvalid,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err,
  output logic                      CYC_O,
  output logic                      STB_O,
  output logic                      WE_O,
  output logic [ADDR_WIDTH-1:0]     ADR_O,
  output logic [DATA_WIDTH-1:0]     DAT_O,
  output logic                      SEL_O,
  output logic                      LOCK_O,
  output logic [SRAM_TGA_WIDTH-1:0] TGA_O,
  output logic [SRAM_TGD_WIDTH-1:0] TGD_O,
  output logic [SRAM_TGC_WIDTH-1:0] TGC_O,
  input  logic [DATA_WIDTH-1:0]     DAT_I,
  input  logic                      ACK_I,
  input  logic                      ERR_I,
  input  logic                      RTY_I
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;
  logic [RW-1:0]         r_retry;
  logic                  r_err;
  logic                  w_abort;

  // A retry beyond the per-beat allowance is escalated to a bus error.
  assign w_abort = ERR_I | (RTY_I & (r_retry == RW'(MAX_RETRY)));

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_len    <= '0;
      r_we     <= 1'b0;
      r_dat    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_retry  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_err   <= 1'b0;
            r_retry <= '0;
            if (i_len != '0) begin
              r_addr  <= i_base_addr;
              r_len   <= i_len;
              r_we    <= i_write;
              r_state <= i_write ? ST_FETCH : ST_REQ;
            end else begin
              r_len   <= '0;
              r_state <= ST_FINISH;
            end
          end
        end
        ST_FETCH: begin
          if (i_wvalid) begin
            r_dat   <= i_wdata;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_abort) begin
            r_err   <= 1'b1;
            r_state <= ST_FINISH;
          end else if (RTY_I) begin
            r_retry <= r_retry + RW'(1);
            r_state <= ST_GAP;
          end else if (ACK_I) begin
            r_retry <= '0;
            if (!r_we) begin
              r_rdata  <= DAT_I;
              r_rvalid <= 1'b1;
            end
            r_addr  <= r_addr + ADDR_WIDTH'(1);
            r_len   <= r_len - LEN_WIDTH'(1);
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          // A pending retry re-issues the held beat without refetching write data.
          if (r_len == '0)
            r_state <= ST_FINISH;
          else if (r_we && (r_retry == '0))
            r_state <= ST_FETCH;
          else
            r_state <= ST_REQ;
        end
        ST_FINISH: begin
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign CYC_O    = (r_state == ST_FETCH) | (r_state == ST_REQ) | (r_state == ST_GAP);
  assign STB_O    = (r_state == ST_REQ);
  assign WE_O     = r_we & CYC_O;
  assign ADR_O    = r_addr;
  assign DAT_O    = r_dat;
  assign o_wready = (r_state == ST_FETCH);
  assign o_busy   = (r_state != ST_IDLE);
  assign o_done   = (r_state == ST_FINISH);
  assign o_err    = (r_state == ST_FINISH) & r_err;
  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;
  assign SEL_O    = 1'b1;
  assign LOCK_O   = 1'b0;
  assign TGA_O    = '0;
  assign TGD_O    = '0;
  assign TGC_O    = '0;

endmodule

// File: tb/tb_sram_block_mentor.sv
// Bench for sram_block_mentor: table of block transfers against a scripted SRAM responder,
// plus hand sequences for zero length, start-while-busy and mid-block reset.
module tb_sram_block_mentor;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic        i_start = 1'b0, i_write = 1'b0, i_wvalid = 1'b0;
  logic [19:0] i_base_addr = '0;
  logic [7:0]  i_len = '0, i_wdata = '0;
  logic        o_wready, o_rvalid, o_busy, o_done, o_err;
  logic [7:0]  o_rdata, DAT_O;
  logic        CYC_O, STB_O, WE_O, SEL_O, LOCK_O;
  logic [19:0] ADR_O;
  logic [0:0]  TGA_O, TGD_O, TGC_O;
  logic [7:0]  DAT_I = '0;
  logic        ACK_I = 1'b0, ERR_I = 1'b0, RTY_I = 1'b0;

  sram_block_mentor dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .i_start(i_start), .i_write(i_write),
    .i_base_addr(i_base_addr), .i_len(i_len), .i_wdata(i_wdata), .i_wvalid(i_wvalid),
    .o_wready(o_wready), .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .LOCK_O(LOCK_O), .TGA_O(TGA_O),
    .TGD_O(TGD_O), .TGC_O(TGC_O), .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I)
  );

  always #5 CLK_I = ~CLK_I;

  // Response codes per STB cycle: 0 ACK, 1 RTY, 2 ERR, 3 ERR+RTY+ACK, 4 RTY+ACK
  typedef struct {
    bit         wr;
    bit [19:0]  base;
    bit [7:0]   len;
    bit [31:0]  wdat;
    bit [23:0]  resp;
    bit         spur;
    int         exp_stb;
    bit [79:0]  exp_adr;
    bit [31:0]  exp_dat;
    int         exp_nrv;
    bit [31:0]  exp_rd;
    bit         exp_err;
    int         exp_rises;
  } vec_t;

  vec_t vecs[11];

  logic [7:0]  mem [bit [19:0]];
  logic [19:0] ev_adr[$];
  logic [7:0]  ev_dat[$];
  logic        ev_we[$];
  logic [7:0]  rd_q[$];
  int          n_done, n_err, n_rises, resp_idx, widx, cur_wlen;
  bit [31:0]   cur_wdat;
  bit [23:0]   cur_resp;
  bit          cur_spur;
  logic        prev_cyc = 1'b0;
  int          checks = 0, failures = 0;

  function automatic vec_t mk(bit wr, bit [19:0] base, bit [7:0] len, bit [31:0] wdat,
                              bit [23:0] resp, bit spur, int stb, bit [79:0] adr,
                              bit [31:0] dat, int nrv, bit [31:0] rd, bit err, int rises);
    vec_t v;
    v.wr = wr; v.base = base; v.len = len; v.wdat = wdat; v.resp = resp; v.spur = spur;
    v.exp_stb = stb; v.exp_adr = adr; v.exp_dat = dat; v.exp_nrv = nrv; v.exp_rd = rd;
    v.exp_err = err; v.exp_rises = rises;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK_I);
    #1;
  endtask

  // SRAM responder, write-data feeder and output monitor, all evaluated mid-cycle
  always @(negedge CLK_I) begin
    logic [2:0] code;
    ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0;
    if (STB_O) begin
      code = (resp_idx < 8) ? cur_resp[3*resp_idx +: 3] : 3'd0;
      resp_idx++;
      case (code)
        3'd1: RTY_I = 1'b1;
        3'd2: ERR_I = 1'b1;
        3'd3: begin ERR_I = 1'b1; RTY_I = 1'b1; ACK_I = 1'b1; end
        3'd4: begin RTY_I = 1'b1; ACK_I = 1'b1; end
        default: ACK_I = 1'b1;
      endcase
      ev_adr.push_back(ADR_O); ev_dat.push_back(DAT_O); ev_we.push_back(WE_O);
      if (WE_O && ACK_I && !RTY_I && !ERR_I) mem[ADR_O] = DAT_O;
      DAT_I = mem.exists(ADR_O) ? mem[ADR_O] : 8'h00;
    end else if (cur_spur) begin
      ERR_I = 1'b1; ACK_I = 1'b1;
    end
    if (o_rvalid) rd_q.push_back(o_rdata);
    if (o_done) n_done++;
    if (o_err) n_err++;
    if (CYC_O && !prev_cyc) n_rises++;
    prev_cyc = CYC_O;
    if (widx < cur_wlen) begin
      i_wvalid = 1'b1;
      i_wdata = cur_wdat[8*widx +: 8];
      if (o_wready) widx++;
    end else begin
      i_wvalid = 1'b0;
    end
  end

  task automatic clear_block(input bit [31:0] wdat, input int wlen, input bit [23:0] resp, input bit spur);
    ev_adr.delete(); ev_dat.delete(); ev_we.delete(); rd_q.delete();
    n_done = 0; n_err = 0; n_rises = 0; resp_idx = 0; widx = 0;
    cur_wdat = wdat; cur_wlen = wlen; cur_resp = resp; cur_spur = spur;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 300; k++) begin
      step();
      if (n_done > 0 && !o_busy) break;
    end
    chk({nm, " finished in budget"}, 32'(k < 300), 32'd1);
    step();
  endtask

  initial begin
    vecs[0]  = mk(1, 20'h01777, 3, 32'h00CBCAC9, 24'h0, 0, 3, {20'h0, 20'h01779, 20'h01778, 20'h01777},
                  32'h00CBCAC9, 0, 32'h0, 0, 1);
    vecs[1]  = mk(0, 20'h01777, 3, 32'h0, 24'h0, 0, 3, {20'h0, 20'h01779, 20'h01778, 20'h01777},
                  32'h0, 3, 32'h00CBCAC9, 0, 1);
    vecs[2]  = mk(0, 20'h12345, 0, 32'h0, 24'h0, 0, 0, 80'h0, 32'h0, 0, 32'h0, 0, 0);
    vecs[3]  = mk(0, 20'hFFFFE, 3, 32'h0, 24'h0, 0, 3, {20'h0, 20'h00000, 20'hFFFFF, 20'hFFFFE},
                  32'h0, 3, 32'h00332211, 0, 1);
    vecs[4]  = mk(1, 20'h00100, 2, 32'h0000A55A, 24'o11, 0, 4, {20'h00101, 20'h00100, 20'h00100, 20'h00100},
                  32'hA55A5A5A, 0, 32'h0, 0, 1);
    vecs[5]  = mk(1, 20'h00200, 2, 32'h00000201, 24'o1111, 0, 4, {20'h00200, 20'h00200, 20'h00200, 20'h00200},
                  32'h01010101, 0, 32'h0, 1, 1);
    vecs[6]  = mk(0, 20'h00300, 4, 32'h0, 24'o20, 0, 2, {20'h0, 20'h0, 20'h00301, 20'h00300},
                  32'h0, 1, 32'h00000077, 1, 1);
    vecs[7]  = mk(0, 20'h00100, 2, 32'h0, 24'h0, 0, 2, {20'h0, 20'h0, 20'h00101, 20'h00100},
                  32'h0, 2, 32'h0000A55A, 0, 1);
    vecs[8]  = mk(0, 20'h00200, 2, 32'h0, 24'h0, 1, 2, {20'h0, 20'h0, 20'h00201, 20'h00200},
                  32'h0, 2, 32'h00005EEE, 0, 1);
    vecs[9]  = mk(0, 20'h00700, 1, 32'h0, 24'o4, 0, 2, {20'h0, 20'h0, 20'h00700, 20'h00700},
                  32'h0, 1, 32'h0000003C, 0, 1);
    vecs[10] = mk(0, 20'h00700, 1, 32'h0, 24'o3, 0, 1, {20'h0, 20'h0, 20'h0, 20'h00700},
                  32'h0, 0, 32'h0, 1, 1);

    mem[20'hFFFFE] = 8'h11; mem[20'hFFFFF] = 8'h22; mem[20'h00000] = 8'h33;
    mem[20'h00300] = 8'h77; mem[20'h00301] = 8'h88; mem[20'h00200] = 8'hEE;
    mem[20'h00201] = 8'h5E; mem[20'h00400] = 8'h44; mem[20'h00401] = 8'h45;
    mem[20'h00700] = 8'h3C;
    clear_block(32'h0, 0, 24'h0, 0);

    step(); step();
    chk("reset CYC_O", 32'(CYC_O), 32'd0);
    chk("reset STB_O", 32'(STB_O), 32'd0);
    chk("reset busy/done/err", {29'd0, o_busy, o_done, o_err}, 32'd0);
    chk("reset wready/rvalid", {30'd0, o_wready, o_rvalid}, 32'd0);
    chk("reset ADR_O", 32'(ADR_O), 32'd0);
    chk("tie-offs SEL/LOCK/TG", {27'd0, SEL_O, LOCK_O, TGA_O, TGD_O, TGC_O}, 32'h10);
    RST_I = 1'b1;
    step();

    for (int v = 0; v < 11; v++) begin
      string nm;
      clear_block(vecs[v].wdat, vecs[v].wr ? int'(vecs[v].len) : 0, vecs[v].resp, vecs[v].spur);
      i_start = 1'b1; i_write = vecs[v].wr; i_base_addr = vecs[v].base; i_len = vecs[v].len;
      step();
      i_start = 1'b0;
      nm = $sformatf("vec%0d", v);
      wait_idle(nm);
      chk({nm, " stb count"}, 32'(ev_adr.size()), 32'(vecs[v].exp_stb));
      for (int i = 0; i < vecs[v].exp_stb && i < ev_adr.size(); i++) begin
        chk($sformatf("%s adr%0d", nm, i), 32'(ev_adr[i]), 32'(vecs[v].exp_adr[20*i +: 20]));
        chk($sformatf("%s we%0d", nm, i), 32'(ev_we[i]), 32'(vecs[v].wr));
        if (vecs[v].wr)
          chk($sformatf("%s dat%0d", nm, i), 32'(ev_dat[i]), 32'(vecs[v].exp_dat[8*i +: 8]));
      end
      chk({nm, " rvalid count"}, 32'(rd_q.size()), 32'(vecs[v].exp_nrv));
      for (int i = 0; i < vecs[v].exp_nrv && i < rd_q.size(); i++)
        chk($sformatf("%s rdata%0d", nm, i), 32'(rd_q[i]), 32'(vecs[v].exp_rd[8*i +: 8]));
      chk({nm, " done pulses"}, 32'(n_done), 32'd1);
      chk({nm, " err pulses"}, 32'(n_err), 32'(vecs[v].exp_err));
      chk({nm, " CYC_O rises"}, 32'(n_rises), 32'(vecs[v].exp_rises));
      chk({nm, " idle after"}, {30'd0, o_busy, CYC_O}, 32'd0);
    end

    // Zero length: done exactly one cycle after start, never a bus cycle
    clear_block(32'h0, 0, 24'h0, 0);
    i_start = 1'b1; i_write = 1'b1; i_base_addr = 20'h00055; i_len = 8'd0;
    step();
    i_start = 1'b0;
    chk("len0 done next cycle", 32'(o_done), 32'd1);
    chk("len0 CYC_O low", 32'(CYC_O), 32'd0);
    chk("len0 err low", 32'(o_err), 32'd0);
    step();
    chk("len0 done single", 32'(o_done), 32'd0);
    chk("len0 busy after", 32'(o_busy), 32'd0);

    // Start while busy is ignored
    clear_block(32'h0, 0, 24'h0, 0);
    i_start = 1'b1; i_write = 1'b0; i_base_addr = 20'h00400; i_len = 8'd2;
    step();
    i_start = 1'b0;
    step();
    i_start = 1'b1; i_write = 1'b1; i_base_addr = 20'h00500; i_len = 8'd5;
    step();
    i_start = 1'b0;
    wait_idle("busy start");
    chk("busy start stb count", 32'(ev_adr.size()), 32'd2);
    if (ev_adr.size() >= 2) chk("busy start adr1", 32'(ev_adr[1]), 32'h00401);
    chk("busy start done", 32'(n_done), 32'd1);
    chk("busy start rdata count", 32'(rd_q.size()), 32'd2);

    // Asynchronous reset in the middle of a write block
    clear_block(32'h04030201, 4, 24'h0, 0);
    i_start = 1'b1; i_write = 1'b1; i_base_addr = 20'h00600; i_len = 8'd4;
    step();
    i_start = 1'b0;
    repeat (5) step();
    chk("mid-block CYC_O before reset", 32'(CYC_O), 32'd1);
    #2 RST_I = 1'b0;
    #1;
    chk("async reset CYC_O", 32'(CYC_O), 32'd0);
    chk("async reset STB_O", 32'(STB_O), 32'd0);
    chk("async reset busy", 32'(o_busy), 32'd0);
    cur_wlen = 0;
    repeat (3) step();
    chk("reset no done", 32'(n_done), 32'd0);
    chk("reset done/err low", {30'd0, o_done, o_err}, 32'd0);
    RST_I = 1'b1;
    repeat (2) step();
    chk("after reset idle", {30'd0, o_busy, CYC_O}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
